// File: rtl/vend_display_formatter.sv
// Binary cents amount to four display digit codes plus decimal point.
// Conversion is an iterative shift-add-3 (double-dabble), one bit per cycle;
// digit outputs are registered only at COMMIT so the display never shows partial results.
// Optional feature macro: VEND_DISP_OVF_DASH_EN (money-mode overflow shows a dash on the
// leftmost digit instead of 9).
module vend_display_formatter #(
  parameter int unsigned AMOUNT_W  = 14,
  parameter int unsigned MONEY_MAX = 9999,
  parameter int unsigned COIN_MAX  = 999
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [AMOUNT_W-1:0] amountCents,
  input  logic                showCoin,
  input  logic [1:0]          coinCode,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic [3:0]          DispVal1,
  output logic [3:0]          DispVal2,
  output logic [3:0]          DispVal3,
  output logic [4:0]          DispVal4,
  output logic                dPoint
);

  localparam int unsigned CntW = $clog2(AMOUNT_W + 1);
  localparam logic [AMOUNT_W-1:0] MoneyMax = AMOUNT_W'(MONEY_MAX);
  localparam logic [AMOUNT_W-1:0] CoinMax  = AMOUNT_W'(COIN_MAX);

  typedef enum logic [1:0] {StIdle, StShift, StCommit} state_e;

  state_e              state_q, state_d;
  logic [AMOUNT_W-1:0] bin_q, bin_d;
  logic [15:0]         bcd_q, bcd_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                coin_q, coin_d;
  logic [1:0]          code_q, code_d;
  logic                ovf_pend_q, ovf_pend_d;
  logic [3:0]          d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
  logic [4:0]          d4_q, d4_d;
  logic                ovf_q, ovf_d;
  logic                done_q, done_d;

  logic [AMOUNT_W-1:0] amt_sat;
  logic                amt_ovf;
  logic [15:0]         bcd_adj;

  // Clamp the incoming amount to the limit of the selected mode.
  always_comb begin
    amt_sat = amountCents;
    amt_ovf = 1'b0;
    if (showCoin) begin
      if (amountCents > CoinMax) begin
        amt_sat = CoinMax;
        amt_ovf = 1'b1;
      end
    end else if (amountCents > MoneyMax) begin
      amt_sat = MoneyMax;
      amt_ovf = 1'b1;
    end
  end

  // Add-3 correction of every BCD nibble that would exceed 9 after doubling.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Next-state logic for the conversion FSM and the committed display registers.
  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    coin_d     = coin_q;
    code_d     = code_q;
    ovf_pend_d = ovf_pend_q;
    d1_d       = d1_q;
    d2_d       = d2_q;
    d3_d       = d3_q;
    d4_d       = d4_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (load) begin
          bin_d      = amt_sat;
          bcd_d      = '0;
          cnt_d      = CntW'(AMOUNT_W);
          coin_d     = showCoin;
          code_d     = coinCode;
          ovf_pend_d = amt_ovf;
          state_d    = StShift;
        end
      end
      StShift: begin
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        cnt_d          = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) state_d = StCommit;
      end
      StCommit: begin
        d1_d = bcd_q[3:0];
        d2_d = bcd_q[7:4];
        d3_d = bcd_q[11:8];
        // Saturation keeps the thousands digit at 0 in coin mode, so it is free for the letter.
        if (coin_q) d4_d = 5'h10 + {3'b000, code_q};
        else        d4_d = {1'b0, bcd_q[15:12]};
`ifdef VEND_DISP_OVF_DASH_EN
        if (!coin_q && ovf_pend_q) begin
          d4_d = 5'h1F;
          d3_d = 4'd9;
          d2_d = 4'd9;
          d1_d = 4'd9;
        end
`endif
        ovf_d   = ovf_pend_q;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset drops any conversion in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      coin_q     <= 1'b0;
      code_q     <= 2'd0;
      ovf_pend_q <= 1'b0;
      d1_q       <= 4'd0;
      d2_q       <= 4'd0;
      d3_q       <= 4'd0;
      d4_q       <= 5'd0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      coin_q     <= coin_d;
      code_q     <= code_d;
      ovf_pend_q <= ovf_pend_d;
      d1_q       <= d1_d;
      d2_q       <= d2_d;
      d3_q       <= d3_d;
      d4_q       <= d4_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
    end
  end

  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign overflow = ovf_q;
  assign DispVal1 = d1_q;
  assign DispVal2 = d2_q;
  assign DispVal3 = d3_q;
  assign DispVal4 = d4_q;
  // The decimal point sits after the dollar units digit in both modes.
  assign dPoint   = 1'b1;

endmodule

// File: tb/tb_vend_display_formatter.sv
// Directed bench for vend_display_formatter: drives at 1 time unit after the rising edge
// and samples there too.
module tb_vend_display_formatter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [13:0] amountCents = '0;
  logic        showCoin = 1'b0;
  logic [1:0]  coinCode = 2'd0;
  logic        busy, done, overflow, dPoint;
  logic [3:0]  DispVal1, DispVal2, DispVal3;
  logic [4:0]  DispVal4;

  int n_checks = 0;
  int n_pass   = 0;
  int lat;
  int ndone;
  logic [4:0] cap4;
  logic [3:0] cap3, cap2, cap1;
  logic       capo;

  vend_display_formatter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .amountCents(amountCents),
    .showCoin   (showCoin),
    .coinCode   (coinCode),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow),
    .DispVal1   (DispVal1),
    .DispVal2   (DispVal2),
    .DispVal3   (DispVal3),
    .DispVal4   (DispVal4),
    .dPoint     (dPoint)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_out(input string tag, input logic [4:0] e4, input logic [3:0] e3,
                           input logic [3:0] e2, input logic [3:0] e1, input logic eo);
    check({tag, ".d4"}, 32'(DispVal4), 32'(e4));
    check({tag, ".d3"}, 32'(DispVal3), 32'(e3));
    check({tag, ".d2"}, 32'(DispVal2), 32'(e2));
    check({tag, ".d1"}, 32'(DispVal1), 32'(e1));
    check({tag, ".ovf"}, 32'(overflow), 32'(eo));
    check({tag, ".dp"}, 32'(dPoint), 32'd1);
  endtask

  // One-cycle load pulse; called at 1 time unit after a rising edge.
  task automatic start(input int amt, input logic coin, input logic [1:0] code);
    amountCents = 14'(amt);
    showCoin    = coin;
    coinCode    = code;
    load        = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
  endtask

  // Edges from the accepting edge until done is seen; 0 means it never came.
  task automatic wait_done(output int l);
    l = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        l = i;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check_out("rst", 5'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Money mode 12.34
    start(1234, 1'b0, 2'd0);
    check("m1234.busy", 32'(busy), 32'd1);
    wait_done(lat);
    check("m1234.lat", 32'(lat), 32'd15);
    check_out("m1234", 5'd1, 4'd2, 4'd3, 4'd4, 1'b0);
    check("m1234.busy_done", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    check("m1234.done_pulse", 32'(done), 32'd0);
    check_out("m1234.hold", 5'd1, 4'd2, 4'd3, 4'd4, 1'b0);

    // Coin mode, quarter letter, 0.25
    start(25, 1'b1, 2'd1);
    wait_done(lat);
    check("c25.lat", 32'(lat), 32'd15);
    check_out("c25", 5'h11, 4'd0, 4'd2, 4'd5, 1'b0);

    // Money-mode saturation
    start(12000, 1'b0, 2'd0);
    wait_done(lat);
    check("m12000.lat", 32'(lat), 32'd15);
`ifdef VEND_DISP_OVF_DASH_EN
    check_out("m12000", 5'h1F, 4'd9, 4'd9, 4'd9, 1'b1);
`else
    check_out("m12000", 5'd9, 4'd9, 4'd9, 4'd9, 1'b1);
`endif

    // Coin-mode saturation keeps the letter
    start(1500, 1'b1, 2'd3);
    wait_done(lat);
    check_out("c1500", 5'h13, 4'd9, 4'd9, 4'd9, 1'b1);

    // Reset during the shift phase
    start(1234, 1'b0, 2'd0);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rstmid.busy_async", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rstmid.busy", 32'(busy), 32'd0);
    check("rstmid.done", 32'(done), 32'd0);
    check_out("rstmid", 5'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    check("rstmid.no_done", 32'(ndone), 32'd0);

    // Load while busy is ignored
    start(42, 1'b0, 2'd0);
    repeat (3) @(posedge clk);
    #1;
    check("busyload.busy", 32'(busy), 32'd1);
    amountCents = 14'd5555;
    load        = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    ndone = 0;
    {cap4, cap3, cap2, cap1, capo} = '0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        if (ndone == 1) {cap4, cap3, cap2, cap1, capo} =
            {DispVal4, DispVal3, DispVal2, DispVal1, overflow};
      end
    end
    check("busyload.ndone", 32'(ndone), 32'd1);
    check("busyload.d4", 32'(cap4), 32'd0);
    check("busyload.d3", 32'(cap3), 32'd0);
    check("busyload.d2", 32'(cap2), 32'd4);
    check("busyload.d1", 32'(cap1), 32'd2);
    check("busyload.ovf", 32'(capo), 32'd0);

    // Back-to-back: 99.99 (exact limit, no overflow) then 00.00
    start(9999, 1'b0, 2'd0);
    wait_done(lat);
    check("m9999.lat", 32'(lat), 32'd15);
    check_out("m9999", 5'd9, 4'd9, 4'd9, 4'd9, 1'b0);
    start(0, 1'b0, 2'd0);
    check("b2b.busy", 32'(busy), 32'd1);
    repeat (7) @(posedge clk);
    #1;
    check_out("b2b.hold", 5'd9, 4'd9, 4'd9, 4'd9, 1'b0);
    wait_done(lat);
    check("b2b.lat", 32'(lat), 32'd8);
    check_out("b2b", 5'd0, 4'd0, 4'd0, 4'd0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
